// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    // Read-mode encodings for the FWFT parameter
    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Width of pointers and level: one extra wrap bit above the index
    function automatic int unsigned fifo_level_w(input int unsigned size);
        return 32'($clog2(size)) + 32'd1;
    endfunction

    // True for a non-zero power of two
    function automatic bit fifo_is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 32'd1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: flop array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int unsigned BITS = 32,
    parameter int unsigned SIZE = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(SIZE)-1:0]  waddr_i,
    input  logic [BITS-1:0]          wdata_i,
    input  logic [$clog2(SIZE)-1:0]  raddr_i,
    output logic [BITS-1:0]          rdata_o
);

    logic [BITS-1:0] mem_q [SIZE];

    // Write accepted entries; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, optional
// first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned SIZE      = 16,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [BITS-1:0]           wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [BITS-1:0]           rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [$clog2(SIZE):0]     level,
    input  logic                      err_clr,
    output logic                      wr_overflow,
    output logic                      rd_underflow
);

    localparam int unsigned AW = 32'($clog2(SIZE));
    localparam int unsigned LW = fifo_level_w(SIZE);

    // Reject illegal configurations at elaboration
    if (!fifo_is_pow2(SIZE) || SIZE < 2) begin : g_bad_size
        $fatal(1, "sync_fifo_flags: SIZE must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > SIZE) begin : g_bad_af
        $fatal(1, "sync_fifo_flags: AF_THRESH out of range 1..SIZE");
    end
    if (AE_THRESH > SIZE - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_flags: AE_THRESH out of range 0..SIZE-1");
    end
    if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [LW-1:0]   level_c;
    logic            full_c;
    logic            empty_c;
    logic            wr_acc_c;
    logic            rd_acc_c;
    logic [BITS-1:0] mem_rdata;

    // Status decoded from registered pointers only, so no input feeds a flag
    always_comb begin
        level_c  = wr_ptr_q - rd_ptr_q;
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_acc_c = wr_en && !full_c;
        rd_acc_c = rd_en && !empty_c;
    end

    // Next-state for pointers and sticky error flags; clear beats a same-cycle set
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr_en && full_c) begin
                ovf_d = 1'b1;
            end
            if (rd_en && empty_c) begin
                unf_d = 1'b1;
            end
        end
    end

    // Pointer and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc_c),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head entry is presented directly; rd_en acknowledges it
        assign rd_data  = mem_rdata;
        assign rd_valid = !empty_c;
    end else begin : g_std
        logic [BITS-1:0] rd_data_q, rd_data_d;
        logic            rd_valid_q, rd_valid_d;

        // Capture the head on an accepted read; hold data otherwise
        always_comb begin
            rd_valid_d = rd_acc_c;
            rd_data_d  = rd_data_q;
            if (rd_acc_c) begin
                rd_data_d = mem_rdata;
            end
        end

        // Standard-mode output register
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign wr_full      = full_c;
    assign rd_empty     = empty_c;
    assign almost_full  = (level_c >= LW'(AF_THRESH));
    assign almost_empty = (level_c <= LW'(AE_THRESH));
    assign level        = level_c;
    assign wr_overflow  = ovf_q;
    assign rd_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a standard-mode and an FWFT instance share all inputs.
module tb_sync_fifo_flags;

    localparam int unsigned BITS = 16;
    localparam int unsigned SIZE = 8;
    localparam int unsigned LW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [BITS-1:0] wr_data;
    logic            rd_en;
    logic            err_clr;

    logic            s_full, s_afull, s_valid, s_empty, s_aempty, s_ovf, s_unf;
    logic [BITS-1:0] s_data;
    logic [LW-1:0]   s_level;
    logic            f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_unf;
    logic [BITS-1:0] f_data;
    logic [LW-1:0]   f_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.BITS(BITS), .SIZE(SIZE), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full),
        .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_data), .rd_valid(s_valid),
        .rd_empty(s_empty), .almost_empty(s_aempty), .level(s_level), .err_clr(err_clr),
        .wr_overflow(s_ovf), .rd_underflow(s_unf)
    );

    sync_fifo_flags #(.BITS(BITS), .SIZE(SIZE), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full),
        .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_data), .rd_valid(f_valid),
        .rd_empty(f_empty), .almost_empty(f_aempty), .level(f_level), .err_clr(err_clr),
        .wr_overflow(f_ovf), .rd_underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Level and flag expectations for both instances given the expected fill level
    task automatic check_state(input string tag, input int lvl);
        chk({tag, ".s_level"},  32'(s_level),  32'(lvl));
        chk({tag, ".f_level"},  32'(f_level),  32'(lvl));
        chk({tag, ".s_full"},   32'(s_full),   32'(lvl == 8));
        chk({tag, ".f_full"},   32'(f_full),   32'(lvl == 8));
        chk({tag, ".s_afull"},  32'(s_afull),  32'(lvl >= 6));
        chk({tag, ".f_afull"},  32'(f_afull),  32'(lvl >= 6));
        chk({tag, ".s_empty"},  32'(s_empty),  32'(lvl == 0));
        chk({tag, ".f_empty"},  32'(f_empty),  32'(lvl == 0));
        chk({tag, ".s_aempty"}, 32'(s_aempty), 32'(lvl <= 1));
        chk({tag, ".f_aempty"}, 32'(f_aempty), 32'(lvl <= 1));
        chk({tag, ".f_valid"},  32'(f_valid),  32'(lvl != 0));
    endtask

    task automatic check_err(input string tag, input logic ovf, input logic unf);
        chk({tag, ".s_ovf"}, 32'(s_ovf), 32'(ovf));
        chk({tag, ".f_ovf"}, 32'(f_ovf), 32'(ovf));
        chk({tag, ".s_unf"}, 32'(s_unf), 32'(unf));
        chk({tag, ".f_unf"}, 32'(f_unf), 32'(unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_state("reset", 0);
        check_err("reset", 1'b0, 1'b0);
        chk("reset.s_valid", 32'(s_valid), 32'd0);
        chk("reset.s_data",  32'(s_data),  32'd0);

        // Fill 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            step();
            check_state($sformatf("fill%0d", i), i);
            if (i == 1) chk("fill1.f_data", 32'(f_data), 32'h1);
        end
        wr_en = 1'b0;

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d.f_head", i), 32'(f_data), 32'(i));
            rd_en = 1'b1;
            step();
            chk($sformatf("drain%0d.s_valid", i), 32'(s_valid), 32'd1);
            chk($sformatf("drain%0d.s_data", i),  32'(s_data),  32'(i));
            check_state($sformatf("drain%0d", i), 8 - i);
        end
        rd_en = 1'b0;
        step();
        chk("idle.s_valid", 32'(s_valid), 32'd0);
        chk("idle.s_hold",  32'(s_data),  32'h8);
        check_err("drained", 1'b0, 1'b0);

        // Refill, then write+read at full: read wins, write flagged
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 16'(32'h10 + 32'(i));
            step();
        end
        check_state("refull", 8);
        chk("ovf.f_head", 32'(f_data), 32'h10);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h00AA;
        step();
        check_state("ovf", 7);
        check_err("ovf", 1'b1, 1'b0);
        chk("ovf.s_data",  32'(s_data),  32'h10);
        chk("ovf.s_valid", 32'(s_valid), 32'd1);
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        check_err("ovf_sticky", 1'b1, 1'b0);
        chk("ovf_idle.s_valid", 32'(s_valid), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("ovdrain%0d.f_head", i), 32'(f_data), 32'h10 + 32'(i));
            rd_en = 1'b1;
            step();
            chk($sformatf("ovdrain%0d.s_data", i), 32'(s_data), 32'h10 + 32'(i));
            check_state($sformatf("ovdrain%0d", i), 7 - i);
        end

        // Write+read at empty: write wins, read flagged
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0055;
        step();
        check_state("unf", 1);
        check_err("unf", 1'b1, 1'b1);
        chk("unf.s_valid", 32'(s_valid), 32'd0);
        chk("unf.f_head",  32'(f_data),  32'h55);
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b1;
        step();
        check_err("clr", 1'b0, 1'b0);
        check_state("clr", 1);
        err_clr = 1'b0; rd_en = 1'b1;
        step();
        chk("unf_rd.s_data", 32'(s_data), 32'h55);
        check_state("unf_rd", 0);

        // Clear beats a same-cycle underflow
        err_clr = 1'b1; rd_en = 1'b1;
        step();
        check_err("clr_prio", 1'b0, 1'b0);
        check_state("clr_prio", 0);
        err_clr = 1'b0; rd_en = 1'b0;

        // Steady streaming at level 3 across pointer wraps
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_data = 16'(32'h100 + 32'(k));
            step();
        end
        check_state("stream_pre", 3);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stream%0d.f_head", k), 32'(f_data), 32'h100 + 32'(k));
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'(32'h103 + 32'(k));
            step();
            chk($sformatf("stream%0d.s_data", k), 32'(s_data), 32'h100 + 32'(k));
            chk($sformatf("stream%0d.s_level", k), 32'(s_level), 32'd3);
            chk($sformatf("stream%0d.f_level", k), 32'(f_level), 32'd3);
        end
        wr_en = 1'b0;
        for (int k = 20; k < 23; k++) begin
            chk($sformatf("stream%0d.f_head", k), 32'(f_data), 32'h100 + 32'(k));
            rd_en = 1'b1;
            step();
            chk($sformatf("stream%0d.s_data", k), 32'(s_data), 32'h100 + 32'(k));
            check_state($sformatf("stream%0d", k), 22 - k);
        end
        rd_en = 1'b0;
        check_err("stream", 1'b0, 1'b0);

        // Reset mid-operation at level 5
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_data = 16'(32'h200 + 32'(k));
            step();
        end
        wr_en = 1'b0;
        check_state("pre_rst", 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state("mid_rst", 0);
        chk("mid_rst.s_valid", 32'(s_valid), 32'd0);
        chk("mid_rst.s_data",  32'(s_data),  32'd0);
        wr_en = 1'b1; wr_data = 16'h0300;
        step();
        wr_en = 1'b0;
        check_state("post_rst_wr", 1);
        chk("post_rst.f_head", 32'(f_data), 32'h300);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("post_rst.s_data",  32'(s_data),  32'h300);
        chk("post_rst.s_valid", 32'(s_valid), 32'd1);
        check_state("post_rst_rd", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
